// File: rtl/sysram_banked.sv
// -----------------------------------------------------------------------------
// sysram_banked
//   Banked system RAM on the shared CPU/MARIA bus. Holds NUM_BANKS independent
//   banks of 2^ADDR_W x DATA_W words. Decodes a one-hot bank select, returns
//   registered read data through a mux with open-bus fill, and runs a hardware
//   clear sequencer that writes CLEAR_VAL into every bank after reset (when
//   AUTO_CLEAR is set) or on request.
//
// Ports
//   memclk      in   bus memory clock
//   reset       in   asynchronous, active-high reset
//   bank_sel    in   one-hot bank chip-select from the system decode
//   addr        in   word address within the selected bank
//   wdata       in   write data
//   rw          in   1 = read, 0 = write
//   clear_req   in   start/restart a full clear (level, sampled each memclk)
//   rdata       out  read data, one memclk after the select
//   busy        out  clear in progress
//   clear_done  out  one-cycle pulse when a clear completes
//   multi_sel   out  one-cycle pulse after a cycle with several bank_sel bits set
//
// Clear sequencer states
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | normal bus operation, waiting for clear_req
//   ST_CLEAR  | sweeping every bank with CLEAR_VAL, bus writes ignored
//   ST_DONE   | sweep finished, clear_done high for this one cycle
// -----------------------------------------------------------------------------
module sysram_banked #(
    parameter int                NUM_BANKS  = 2,
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = 8'h00,
    parameter logic [DATA_W-1:0] OPEN_BUS   = 8'h46,
    parameter bit                AUTO_CLEAR = 1'b1
) (
    input  logic                 memclk,
    input  logic                 reset,
    input  logic [NUM_BANKS-1:0] bank_sel,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 rw,
    input  logic                 clear_req,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 multi_sel
);

    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // Counter carries one spare bit so the last address can be compared
    // without relying on wrap-around.
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                           state;
    logic [ADDR_W:0]                  clr_cnt;
    logic                             clearing;

    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_q;

    logic                             sel_hit;
    logic [SEL_W-1:0]                 sel_idx;
    logic                             sel_vld;
    logic [SEL_W-1:0]                 sel_q;
    logic                             rd_busy;

    // -------------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state      <= AUTO_CLEAR ? ST_CLEAR : ST_IDLE;
            clr_cnt    <= '0;
            busy       <= AUTO_CLEAR;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // A restart request wins over the terminal count; the
                    // current cycle's write still happens at the old address.
                    if (clear_req) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == LAST_CNT) begin
                        state      <= ST_DONE;
                        clr_cnt    <= '0;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign clearing = (state == ST_CLEAR);

    // While clearing, the sweep owns the write port of every bank and the bus
    // write is dropped.
    assign wr_addr = clearing ? clr_cnt[ADDR_W-1:0] : addr;
    assign wr_data = clearing ? CLEAR_VAL : wdata;

    // -------------------------------------------------------------------------
    // Storage: one synchronous, read-first RAM per bank. The read port always
    // follows the bus address so the mux below only has to pick a bank.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_W-1:0] mem [2**ADDR_W];
        logic [DATA_W-1:0] q;
        logic              we;

        assign we = clearing | (~rw & bank_sel[g]);

        always_ff @(posedge memclk) begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            q <= mem[addr];
        end

        assign bank_q[g] = q;
    end

    // -------------------------------------------------------------------------
    // Bank-select decode: lowest set bit wins when the select is not one-hot.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (bank_sel[i]) begin
                sel_hit = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end
    end

    // rd_busy remembers that the read sampled on the last edge happened during
    // a sweep, so rdata keeps its open-bus value while reset is held even when
    // the sequencer comes out of reset busy.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            sel_vld   <= 1'b0;
            sel_q     <= '0;
            rd_busy   <= 1'b0;
            multi_sel <= 1'b0;
        end else begin
            sel_vld   <= sel_hit;
            sel_q     <= sel_idx;
            rd_busy   <= clearing;
            multi_sel <= ($countones(bank_sel) > 1);
        end
    end

    // Every term here comes from a register, so rdata has no combinational
    // path from the bus inputs.
    always_comb begin
        rdata = OPEN_BUS;
        if (rd_busy) begin
            rdata = CLEAR_VAL;
        end else if (sel_vld) begin
            rdata = bank_q[sel_q];
        end
    end

endmodule
